// File: rtl/blackjack_table_ctrl.sv
// Multi-seat blackjack round controller: deal, player turns, dealer play, settlement.
// Optional macro DEALER_HITS_SOFT17_EN makes the dealer also draw on a soft DEALER_STAND.
module blackjack_table_ctrl #(
  parameter int NUM_SEATS    = 2,
  parameter int MAX_CARDS    = 5,
  parameter int DEALER_STAND = 17,
  parameter int SUM_W        = 6
) (
  input  logic                     i_clk,
  input  logic                     i_reset_n,
  input  logic                     i_start,
  input  logic                     i_hit,
  input  logic                     i_stand,
  output logic                     o_card_req,
  input  logic                     i_card_valid,
  input  logic [3:0]               i_card_rank,
  output logic [1:0]               o_seat,
  output logic [3:0]               o_state,
  output logic [NUM_SEATS*SUM_W-1:0] o_player_sums,
  output logic [SUM_W-1:0]         o_dealer_sum,
  output logic [NUM_SEATS*2-1:0]   o_results,
  output logic                     o_round_done
);

  localparam int CW = $clog2(MAX_CARDS + 1);
  localparam logic [2:0] DEALER = 3'(NUM_SEATS);
  localparam logic [3:0] DEAL_TOTAL = 4'(2 * (NUM_SEATS + 1));
  localparam logic [1:0] RES_WIN  = 2'b01;
  localparam logic [1:0] RES_LOSE = 2'b10;
  localparam logic [1:0] RES_TIE  = 2'b11;

  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_DEAL     = 4'd1,
    S_CHECK_BJ = 4'd2,
    S_PLAYER   = 4'd3,
    S_DEALER   = 4'd4,
    S_SETTLE   = 4'd5,
    S_DONE     = 4'd6
  } state_t;

  state_t                 state;
  logic [SUM_W-1:0]       hard [NUM_SEATS+1];
  logic [CW-1:0]          cnt  [NUM_SEATS+1];
  logic [NUM_SEATS:0]     ace;
  logic [NUM_SEATS-1:0]   fin;
  logic [2:0]             seat;
  logic [3:0]             deal_cnt;
  logic                   card_req;
  logic [NUM_SEATS*2-1:0] results;

  logic [SUM_W-1:0]       eff [NUM_SEATS+1];
  logic [NUM_SEATS:0]     bj;
  logic [NUM_SEATS:0]     bust;
  logic [NUM_SEATS:0]     charlie;
  logic [SUM_W-1:0]       seat_eff;
  logic [CW-1:0]          seat_cnt;
  logic                   seat_done;
  logic                   dealer_draw;
  logic                   soft_extra;
  logic                   all_bust;
  logic                   take;
  logic                   clear_hands;
  logic [SUM_W-1:0]       card_val;
  logic [2:0]             first_open;
  logic [2:0]             after_open;
  logic [NUM_SEATS*2-1:0] settle_res;

  // Ranks outside 1..10 (faces and illegal codes) all score as ten.
  function automatic logic [SUM_W-1:0] rank_value(input logic [3:0] rank);
    logic [SUM_W-1:0] v;
    if (rank >= 4'd1 && rank <= 4'd10) v = SUM_W'(rank);
    else v = SUM_W'(10);
    return v;
  endfunction

  // Lowest seat index >= from that is still playing; DEALER when none remain.
  function automatic logic [2:0] next_open(input logic [2:0] from,
                                           input logic [NUM_SEATS-1:0] done_mask);
    logic [2:0] pick;
    pick = DEALER;
    for (int i = NUM_SEATS - 1; i >= 0; i--) begin
      if (3'(i) >= from && !done_mask[i]) pick = 3'(i);
      else pick = pick;
    end
    return pick;
  endfunction

  // Per-hand scoring flags derived from registered hard sums and ace flags.
  always_comb begin
    for (int i = 0; i <= NUM_SEATS; i++) begin
      if (ace[i] && hard[i] <= SUM_W'(11)) eff[i] = hard[i] + SUM_W'(10);
      else eff[i] = hard[i];
      bj[i]      = (cnt[i] == CW'(2)) && (eff[i] == SUM_W'(21));
      bust[i]    = eff[i] > SUM_W'(21);
      charlie[i] = (cnt[i] == CW'(MAX_CARDS)) && !bust[i];
    end
  end

  // Active-seat view, dealer draw decision and seat hand-off targets.
  always_comb begin
    seat_eff = '0;
    seat_cnt = '0;
    for (int i = 0; i <= NUM_SEATS; i++) begin
      if (seat == 3'(i)) begin
        seat_eff = eff[i];
        seat_cnt = cnt[i];
      end else begin
        seat_eff = seat_eff;
        seat_cnt = seat_cnt;
      end
    end
    seat_done = (seat_eff >= SUM_W'(21)) || (seat_cnt == CW'(MAX_CARDS));
`ifdef DEALER_HITS_SOFT17_EN
    soft_extra = (eff[NUM_SEATS] == SUM_W'(DEALER_STAND)) && ace[NUM_SEATS] &&
                 (hard[NUM_SEATS] <= SUM_W'(11));
`else
    soft_extra = 1'b0;
`endif
    dealer_draw = ((eff[NUM_SEATS] < SUM_W'(DEALER_STAND)) || soft_extra) &&
                  (cnt[NUM_SEATS] < CW'(MAX_CARDS));
    all_bust    = &bust[NUM_SEATS-1:0];
    take        = card_req && i_card_valid;
    clear_hands = (state == S_IDLE || state == S_DONE) && i_start;
    card_val    = rank_value(i_card_rank);
    first_open  = next_open(3'd0, bj[NUM_SEATS-1:0]);
    after_open  = next_open(seat + 3'd1, fin);
  end

  // Settlement: first matching rule decides each seat.
  always_comb begin
    settle_res = '0;
    for (int i = 0; i < NUM_SEATS; i++) begin
      if (bust[i])                                 settle_res[2*i +: 2] = RES_LOSE;
      else if (bj[i] && bj[NUM_SEATS])             settle_res[2*i +: 2] = RES_TIE;
      else if (bj[i])                              settle_res[2*i +: 2] = RES_WIN;
      else if (bj[NUM_SEATS])                      settle_res[2*i +: 2] = RES_LOSE;
      else if (charlie[i])                         settle_res[2*i +: 2] = RES_WIN;
      else if (bust[NUM_SEATS])                    settle_res[2*i +: 2] = RES_WIN;
      else if (charlie[NUM_SEATS])                 settle_res[2*i +: 2] = RES_LOSE;
      else if (eff[i] > eff[NUM_SEATS])            settle_res[2*i +: 2] = RES_WIN;
      else if (eff[i] == eff[NUM_SEATS])           settle_res[2*i +: 2] = RES_TIE;
      else                                         settle_res[2*i +: 2] = RES_LOSE;
    end
  end

  // Hand storage: cleared at round start, one card added per completed handshake.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      for (int i = 0; i <= NUM_SEATS; i++) begin
        hard[i] <= '0;
        cnt[i]  <= '0;
      end
      ace <= '0;
    end else if (clear_hands) begin
      for (int i = 0; i <= NUM_SEATS; i++) begin
        hard[i] <= '0;
        cnt[i]  <= '0;
      end
      ace <= '0;
    end else if (take) begin
      for (int i = 0; i <= NUM_SEATS; i++) begin
        if (seat == 3'(i)) begin
          hard[i] <= hard[i] + card_val;
          cnt[i]  <= cnt[i] + CW'(1);
          if (i_card_rank == 4'd1) ace[i] <= 1'b1;
        end
      end
    end
  end

  // Round sequencing FSM; card_req drops on the edge that consumes the card.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state    <= S_IDLE;
      fin      <= '0;
      seat     <= 3'd0;
      deal_cnt <= 4'd0;
      card_req <= 1'b0;
      results  <= '0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (i_start) begin
            state    <= S_DEAL;
            fin      <= '0;
            seat     <= 3'd0;
            deal_cnt <= 4'd0;
            card_req <= 1'b0;
            results  <= '0;
          end
        end
        S_DEAL: begin
          if (card_req) begin
            if (i_card_valid) begin
              card_req <= 1'b0;
              deal_cnt <= deal_cnt + 4'd1;
              seat     <= (seat == DEALER) ? 3'd0 : seat + 3'd1;
            end
          end else if (deal_cnt == DEAL_TOTAL) begin
            state <= S_CHECK_BJ;
          end else begin
            card_req <= 1'b1;
          end
        end
        S_CHECK_BJ: begin
          if (bj[NUM_SEATS]) begin
            state <= S_SETTLE;
            seat  <= DEALER;
          end else begin
            fin   <= bj[NUM_SEATS-1:0];
            seat  <= first_open;
            state <= (first_open == DEALER) ? S_DEALER : S_PLAYER;
          end
        end
        S_PLAYER: begin
          if (card_req) begin
            if (i_card_valid) card_req <= 1'b0;
          end else if (seat_done || i_stand) begin
            for (int i = 0; i < NUM_SEATS; i++) begin
              if (seat == 3'(i)) fin[i] <= 1'b1;
            end
            seat <= after_open;
            if (after_open == DEALER) state <= S_DEALER;
          end else if (i_hit) begin
            card_req <= 1'b1;
          end
        end
        S_DEALER: begin
          if (card_req) begin
            if (i_card_valid) card_req <= 1'b0;
          end else if (all_bust || !dealer_draw) begin
            state <= S_SETTLE;
          end else begin
            card_req <= 1'b1;
          end
        end
        S_SETTLE: begin
          results <= settle_res;
          state   <= S_DONE;
        end
        default: begin
          state    <= S_IDLE;
          card_req <= 1'b0;
        end
      endcase
    end
  end

  // Output mapping; the dealer total stays hidden until the dealer plays.
  always_comb begin
    o_player_sums = '0;
    for (int i = 0; i < NUM_SEATS; i++) o_player_sums[i*SUM_W +: SUM_W] = eff[i];
    if (state == S_DEALER || state == S_SETTLE || state == S_DONE) o_dealer_sum = eff[NUM_SEATS];
    else o_dealer_sum = '0;
    o_card_req   = card_req;
    o_seat       = seat[1:0];
    o_state      = state;
    o_results    = results;
    o_round_done = (state == S_DONE);
  end

endmodule

// File: tb/tb_blackjack_table_ctrl.sv
// Directed self-checking bench for blackjack_table_ctrl with two seats.
module tb_blackjack_table_ctrl;

  localparam logic [3:0] ST_IDLE   = 4'd0;
  localparam logic [3:0] ST_DEAL   = 4'd1;
  localparam logic [3:0] ST_PLAYER = 4'd3;
  localparam logic [3:0] ST_DONE   = 4'd6;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        hit = 1'b0;
  logic        stand = 1'b0;
  logic        card_valid = 1'b0;
  logic [3:0]  card_rank = 4'd0;
  logic        card_req;
  logic [1:0]  seat;
  logic [3:0]  state;
  logic [11:0] psums;
  logic [5:0]  dsum;
  logic [3:0]  results;
  logic        round_done;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  blackjack_table_ctrl #(.NUM_SEATS(2), .MAX_CARDS(5), .DEALER_STAND(17), .SUM_W(6)) dut (
    .i_clk(clk), .i_reset_n(rst_n), .i_start(start), .i_hit(hit), .i_stand(stand),
    .o_card_req(card_req), .i_card_valid(card_valid), .i_card_rank(card_rank),
    .o_seat(seat), .o_state(state), .o_player_sums(psums), .o_dealer_sum(dsum),
    .o_results(results), .o_round_done(round_done)
  );

  task automatic give_card(input logic [3:0] rank);
    int k;
    for (k = 0; k < 100; k++) begin
      if (card_req) break;
      @(negedge clk);
    end
    if (k == 100) begin
      checks++; errors++;
      $display("FAIL card_req_timeout got 0 want 1 (rank %0d)", rank);
    end
    card_valid = 1'b1;
    card_rank  = rank;
    @(negedge clk);
    card_valid = 1'b0;
  endtask

  task automatic wait_state(input logic [3:0] want);
    int k;
    for (k = 0; k < 100; k++) begin
      if (state == want) break;
      @(negedge clk);
    end
    checks++;
    if (state !== want) begin
      errors++;
      $display("FAIL wait_state got %0d want %0d", state, want);
    end
  endtask

  task automatic pulse_start();
    start = 1'b1; @(negedge clk); start = 1'b0;
  endtask

  task automatic pulse_hit();
    hit = 1'b1; @(negedge clk); hit = 1'b0;
  endtask

  task automatic pulse_stand();
    stand = 1'b1; @(negedge clk); stand = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks++;
    if ({state, card_req, seat, psums, dsum, results, round_done} !== 31'd0) begin
      errors++;
      $display("FAIL reset_outputs got st=%0d req=%b seat=%0d sums=%h res=%b want all 0",
               state, card_req, seat, psums, results);
    end
    rst_n = 1'b1;
    @(negedge clk);
    card_valid = 1'b1; card_rank = 4'd10;
    @(negedge clk);
    card_valid = 1'b0;
    checks++;
    if (psums !== 12'd0 || card_req !== 1'b0 || state !== ST_IDLE) begin
      errors++;
      $display("FAIL idle_valid_ignored got sums=%h req=%b st=%0d want 0 0 0", psums, card_req, state);
    end
  endtask

  task automatic test_basic_round();
    pulse_start();
    give_card(4'd10); give_card(4'd5); give_card(4'd10);
    give_card(4'd9);  give_card(4'd6); give_card(4'd7);
    wait_state(ST_PLAYER);
    checks++;
    if (psums !== {6'd11, 6'd19} || dsum !== 6'd0 || seat !== 2'd0) begin
      errors++;
      $display("FAIL t1_after_deal got sums=%h dsum=%0d seat=%0d want %h 0 0", psums, dsum, seat, {6'd11, 6'd19});
    end
    pulse_stand();
    checks++;
    if (seat !== 2'd1) begin errors++; $display("FAIL t1_seat_after_stand got %0d want 1", seat); end
    pulse_hit();
    give_card(4'd10);
    wait_state(ST_DONE);
    checks++;
    if (results !== 4'b0101 || dsum !== 6'd17 || round_done !== 1'b1 || psums !== {6'd21, 6'd19}) begin
      errors++;
      $display("FAIL t1_final got res=%b dsum=%0d done=%b sums=%h want 0101 17 1 %h",
               results, dsum, round_done, psums, {6'd21, 6'd19});
    end
  endtask

  task automatic test_dealer_blackjack();
    int saw_player;
    saw_player = 0;
    pulse_start();
    give_card(4'd1); give_card(4'd10); give_card(4'd1);
    give_card(4'd12); give_card(4'd9); give_card(4'd13);
    for (int k = 0; k < 20; k++) begin
      if (state == ST_PLAYER) saw_player = 1;
      if (state == ST_DONE) break;
      @(negedge clk);
    end
    checks++;
    if (saw_player != 0 || state !== ST_DONE) begin
      errors++;
      $display("FAIL t2_skip_player got saw_player=%0d st=%0d want 0 6", saw_player, state);
    end
    checks++;
    if (results !== 4'b1011 || dsum !== 6'd21) begin
      errors++;
      $display("FAIL t2_results got res=%b dsum=%0d want 1011 21", results, dsum);
    end
  endtask

  task automatic test_soft_and_bust();
    pulse_start();
    give_card(4'd1); give_card(4'd10); give_card(4'd10);
    give_card(4'd6); give_card(4'd8);  give_card(4'd5);
    wait_state(ST_PLAYER);
    checks++;
    if (psums !== {6'd18, 6'd17}) begin errors++; $display("FAIL t3_soft17 got %h want %h", psums, {6'd18, 6'd17}); end
    pulse_hit();
    give_card(4'd10);
    checks++;
    if (psums !== {6'd18, 6'd17}) begin errors++; $display("FAIL t3_hard17 got %h want %h", psums, {6'd18, 6'd17}); end
    pulse_hit();
    give_card(4'd5);
    checks++;
    if (psums[5:0] !== 6'd22) begin errors++; $display("FAIL t3_bust_sum got %0d want 22", psums[5:0]); end
    @(negedge clk);
    checks++;
    if (seat !== 2'd1) begin errors++; $display("FAIL t3_auto_end_seat got %0d want 1", seat); end
    pulse_stand();
    give_card(4'd3);
    wait_state(ST_DONE);
    checks++;
    if (results !== 4'b1110 || dsum !== 6'd18) begin
      errors++;
      $display("FAIL t3_results got res=%b dsum=%0d want 1110 18", results, dsum);
    end
  endtask

  task automatic test_charlie();
    pulse_start();
    give_card(4'd2); give_card(4'd10); give_card(4'd10);
    give_card(4'd2); give_card(4'd9);  give_card(4'd10);
    wait_state(ST_PLAYER);
    pulse_hit(); give_card(4'd3);
    pulse_hit(); give_card(4'd2);
    pulse_hit(); give_card(4'd4);
    @(negedge clk);
    checks++;
    if (seat !== 2'd1 || psums[5:0] !== 6'd13) begin
      errors++;
      $display("FAIL t4_charlie_end got seat=%0d sum=%0d want 1 13", seat, psums[5:0]);
    end
    pulse_stand();
    wait_state(ST_DONE);
    checks++;
    if (results !== 4'b1001 || dsum !== 6'd20) begin
      errors++;
      $display("FAIL t4_results got res=%b dsum=%0d want 1001 20", results, dsum);
    end
  endtask

  task automatic test_dealer_soft17();
    int reqs;
    reqs = 0;
    pulse_start();
    give_card(4'd10); give_card(4'd10); give_card(4'd1);
    give_card(4'd10); give_card(4'd9);  give_card(4'd6);
    wait_state(ST_PLAYER);
    pulse_stand();
    pulse_stand();
`ifdef DEALER_HITS_SOFT17_EN
    give_card(4'd2);
    for (int k = 0; k < 20; k++) begin
      if (card_req) reqs++;
      if (state == ST_DONE) break;
      @(negedge clk);
    end
    checks++;
    if (reqs != 0 || results !== 4'b1101 || dsum !== 6'd19) begin
      errors++;
      $display("FAIL t5_soft17_hit got reqs=%0d res=%b dsum=%0d want 0 1101 19", reqs, results, dsum);
    end
`else
    for (int k = 0; k < 20; k++) begin
      if (card_req) reqs++;
      if (state == ST_DONE) break;
      @(negedge clk);
    end
    checks++;
    if (reqs != 0 || results !== 4'b0101 || dsum !== 6'd17 || state !== ST_DONE) begin
      errors++;
      $display("FAIL t5_soft17_stand got reqs=%0d res=%b dsum=%0d st=%0d want 0 0101 17 6",
               reqs, results, dsum, state);
    end
`endif
  endtask

  task automatic test_stall_and_abort();
    int bad;
    bad = 0;
    pulse_start();
    give_card(4'd3); give_card(4'd4);
    @(negedge clk);
    for (int k = 0; k < 5; k++) begin
      if (card_req !== 1'b1 || psums !== {6'd4, 6'd3} || state !== ST_DEAL) bad++;
      hit = (k == 2);
      @(negedge clk);
    end
    hit = 1'b0;
    checks++;
    if (bad != 0) begin errors++; $display("FAIL t6_stall got bad_cycles=%0d want 0", bad); end
    give_card(4'd5); give_card(4'd6); give_card(4'd7); give_card(4'd8);
    wait_state(ST_PLAYER);
    checks++;
    if (psums !== {6'd11, 6'd9}) begin errors++; $display("FAIL t6_after_stall got %h want %h", psums, {6'd11, 6'd9}); end
    pulse_hit();
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({state, card_req, seat, psums, dsum, results, round_done} !== 31'd0) begin
      errors++;
      $display("FAIL t6_abort got st=%0d req=%b seat=%0d sums=%h res=%b want all 0",
               state, card_req, seat, psums, results);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (state !== ST_IDLE || card_req !== 1'b0) begin
      errors++;
      $display("FAIL t6_post_abort got st=%0d req=%b want 0 0", state, card_req);
    end
  endtask

  initial begin
    test_reset();
    test_basic_round();
    test_dealer_blackjack();
    test_soft_and_bust();
    test_charlie();
    test_dealer_soft17();
    test_stall_and_abort();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
